// File: rtl/sa_pkg.sv
`default_nettype none
// ============================================================================
// Module : sa_pkg
// Brief  : Shared widths, operand/accumulator types and controller states for
//          the sa_core output-stationary systolic MAC array.
// Rev    : 1.0  initial release
// ============================================================================
package sa_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int PROD_W = 2 * DATA_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ACC_W-1:0]  acc_t;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Unsigned 8x8 -> 16-bit product, zero-extended to accumulator width
  function automatic acc_t mac_ext(input data_t a, input data_t w);
    logic [PROD_W-1:0] p;
    p = PROD_W'(a) * PROD_W'(w);
    return ACC_W'(p);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sa_pe.sv
`default_nettype none
// ============================================================================
// Module : sa_pe
// Brief  : One processing element. Forwards activation (right) and weight
//          (down) with their tags, accumulates a*w when both tags are set and
//          clears on the tile's last beat. The finished sum enters a delay
//          line of DLY stages so every PE's result emerges on the same cycle.
// Rev    : 1.0  initial release
// ============================================================================
module sa_pe
  import sa_pkg::*;
#(
  parameter int DLY = 1    // >= 1; 2*ROWS-1-r-c for PE(r,c)
) (
  input  logic  clk,
  input  logic  rstn,
  input  logic  i_stall,
  input  data_t i_a,
  input  logic  i_a_vld,
  input  logic  i_a_last,
  input  data_t i_w,
  input  logic  i_w_vld,
  output data_t o_a,
  output logic  o_a_vld,
  output logic  o_a_last,
  output data_t o_w,
  output logic  o_w_vld,
  output acc_t  o_res
);

  data_t r_a;
  data_t r_w;
  logic  r_a_vld;
  logic  r_a_last;
  logic  r_w_vld;
  acc_t  r_acc;
  acc_t  r_dly [DLY];

  logic  w_mac;
  acc_t  w_sum;

  assign w_mac = i_a_vld & i_w_vld;
  assign w_sum = r_acc + mac_ext(i_a, i_w);

  // Operand forwarding, MAC with per-PE clear at the tile's last beat, result delay line
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_a      <= '0;
      r_w      <= '0;
      r_a_vld  <= 1'b0;
      r_a_last <= 1'b0;
      r_w_vld  <= 1'b0;
      r_acc    <= '0;
      for (int k = 0; k < DLY; k++) r_dly[k] <= '0;
    end else if (!i_stall) begin
      r_a      <= i_a;
      r_w      <= i_w;
      r_a_vld  <= i_a_vld;
      r_a_last <= i_a_last;
      r_w_vld  <= i_w_vld;
      if (w_mac) r_acc <= i_a_last ? '0 : w_sum;
      // Stage 0 only carries a value on the last-beat cycle; the line is a true
      // pipeline so a later tile end at this PE cannot overwrite it early.
      r_dly[0] <= (w_mac && i_a_last) ? w_sum : '0;
      for (int k = 1; k < DLY; k++) r_dly[k] <= r_dly[k-1];
    end
  end

  assign o_a      = r_a;
  assign o_w      = r_w;
  assign o_a_vld  = r_a_vld;
  assign o_a_last = r_a_last;
  assign o_w_vld  = r_w_vld;
  assign o_res    = r_dly[DLY-1];

endmodule
`default_nettype wire

// File: rtl/sa_core.sv
`default_nettype none
// ============================================================================
// Module : sa_core
// Brief  : ROWS x ROWS output-stationary systolic MAC array with input skew,
//          tile-end tracking, a double-role output buffer drained one column
//          per outread, and a RUN/HOLD controller that freezes the array when
//          a tile finishes while the buffer is still occupied.
// Rev    : 1.0  initial release
// ============================================================================
module sa_core
  import sa_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int KDEPTH = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  data_t           ainport [ROWS],
  input  data_t           winport [ROWS],
  input  logic            inpvalid,
  input  logic            outread,
  output acc_t            routport [ROWS],
  output logic [0:ROWS-1] rvalidport
);

  localparam int c_RD_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int c_CNT_W = $clog2(KDEPTH + 1);
  localparam int c_TEND  = 2 * ROWS;

  // Inter-PE operand fabric: a flows right along rows, w flows down columns
  data_t w_a   [ROWS][ROWS+1];
  logic  w_av  [ROWS][ROWS+1];
  logic  w_al  [ROWS][ROWS+1];
  data_t w_w   [ROWS+1][ROWS];
  logic  w_wv  [ROWS+1][ROWS];
  acc_t  w_res [ROWS][ROWS];

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_TEND-1:0]  r_tend;
  acc_t               r_buf [ROWS][ROWS];
  logic               r_full;
  logic [c_RD_W-1:0]  r_rdptr;

  logic w_last_beat;
  logic w_accept;
  logic w_tend;
  logic w_final_pop;
  logic w_copy;
  logic w_stall;

  assign w_last_beat = (r_cnt == c_CNT_W'(KDEPTH - 1));
  assign w_tend      = r_tend[c_TEND-1];
  assign w_final_pop = outread && r_full && (r_rdptr == c_RD_W'(ROWS - 1));
  // A finished tile copies when the buffer is free or is being emptied on this edge
  assign w_copy      = w_tend && (!r_full || w_final_pop);
  // Freeze covers the entry edge as well, so the aligned results never shift away
  assign w_stall     = w_tend && !w_copy;
  assign w_accept    = inpvalid && (r_state == RUN) && !w_stall;

  // Row skew: row r activation delayed r cycles behind the sampling register
  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    data_t r_sa [r+1];
    logic  r_sv [r+1];
    logic  r_sl [r+1];

    // Sample the beat with its tag and last-beat marker, then shift
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int k = 0; k <= r; k++) begin
          r_sa[k] <= '0;
          r_sv[k] <= 1'b0;
          r_sl[k] <= 1'b0;
        end
      end else if (!w_stall) begin
        r_sa[0] <= ainport[r];
        r_sv[0] <= w_accept;
        r_sl[0] <= w_accept && w_last_beat;
        for (int k = 1; k <= r; k++) begin
          r_sa[k] <= r_sa[k-1];
          r_sv[k] <= r_sv[k-1];
          r_sl[k] <= r_sl[k-1];
        end
      end
    end

    assign w_a[r][0]  = r_sa[r];
    assign w_av[r][0] = r_sv[r];
    assign w_al[r][0] = r_sl[r];
  end

  // Column skew: column c weight delayed c cycles behind the sampling register
  for (genvar c = 0; c < ROWS; c++) begin : g_wskew
    data_t r_sw  [c+1];
    logic  r_swv [c+1];

    // Sample the weight with its tag, then shift
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int k = 0; k <= c; k++) begin
          r_sw[k]  <= '0;
          r_swv[k] <= 1'b0;
        end
      end else if (!w_stall) begin
        r_sw[0]  <= winport[c];
        r_swv[0] <= w_accept;
        for (int k = 1; k <= c; k++) begin
          r_sw[k]  <= r_sw[k-1];
          r_swv[k] <= r_swv[k-1];
        end
      end
    end

    assign w_w[0][c]  = r_sw[c];
    assign w_wv[0][c] = r_swv[c];
  end

  // PE grid; PE(r,c) result delay makes every anti-diagonal land together
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < ROWS; c++) begin : g_col
      sa_pe #(
        .DLY (2 * ROWS - 1 - r - c)
      ) u_pe (
        .clk      (clk),
        .rstn     (rstn),
        .i_stall  (w_stall),
        .i_a      (w_a[r][c]),
        .i_a_vld  (w_av[r][c]),
        .i_a_last (w_al[r][c]),
        .i_w      (w_w[r][c]),
        .i_w_vld  (w_wv[r][c]),
        .o_a      (w_a[r][c+1]),
        .o_a_vld  (w_av[r][c+1]),
        .o_a_last (w_al[r][c+1]),
        .o_w      (w_w[r+1][c]),
        .o_w_vld  (w_wv[r+1][c]),
        .o_res    (w_res[r][c])
      );
    end

    // Right-edge and bottom-edge forwarding has no consumer
    logic w_edge_unused;
    assign w_edge_unused = ^{w_a[r][ROWS], w_av[r][ROWS], w_al[r][ROWS],
                             w_w[ROWS][r], w_wv[ROWS][r]};
  end

  // Beat counter: counts accepted beats, wraps at the end of each tile
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= w_last_beat ? '0 : r_cnt + c_CNT_W'(1);
    end
  end

  // Tile-end timer: marks the cycle 2*ROWS after each last beat
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tend <= '0;
    end else if (!w_stall) begin
      r_tend <= {r_tend[c_TEND-2:0], w_accept && w_last_beat};
    end
  end

  // Controller: HOLD while a finished tile waits for the buffer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= RUN;
    end else begin
      r_state <= w_stall ? HOLD : RUN;
    end
  end

  // Output buffer: tile copy takes precedence over the column pop
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < ROWS; c++)
          r_buf[r][c] <= '0;
      r_full  <= 1'b0;
      r_rdptr <= '0;
    end else if (w_copy) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < ROWS; c++)
          r_buf[r][c] <= w_res[r][c];
      r_full  <= 1'b1;
      r_rdptr <= '0;
    end else if (outread && r_full) begin
      if (r_rdptr == c_RD_W'(ROWS - 1)) begin
        r_full  <= 1'b0;
        r_rdptr <= '0;
      end else begin
        r_rdptr <= r_rdptr + c_RD_W'(1);
      end
    end
  end

  // Present the current column, zero when the buffer is empty
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      routport[r] = r_full ? r_buf[r][r_rdptr] : '0;
    end
  end

  assign rvalidport = {ROWS{r_full}};

endmodule
`default_nettype wire

// File: tb/tb_sa_core.sv
`default_nettype none
// ============================================================================
// Module : tb_sa_core
// Brief  : Scoreboard bench for sa_core. Stimulus pushes hand-computed column
//          results into queues; monitors pop and compare on every column read.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sa_core;
  import sa_pkg::*;

  localparam int R1 = 8;
  localparam int K1 = 8;
  localparam int R2 = 2;
  localparam int K2 = 66052;      // 66052*65025 = 4295031300 -> wraps to 64004

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn1, rstn2;
  data_t         a1 [R1], w1 [R1];
  data_t         a2 [R2], w2 [R2];
  logic          v_in1, v_in2, rd1, rd2;
  acc_t          res1 [R1];
  acc_t          res2 [R2];
  logic [0:R1-1] rv1;
  logic [0:R2-1] rv2;

  int   n_checks = 0;
  int   n_pass   = 0;
  acc_t q1 [$];
  acc_t q2 [$];

  sa_core #(.ROWS(R1), .KDEPTH(K1)) u_dut1 (
    .clk(clk), .rstn(rstn1), .ainport(a1), .winport(w1), .inpvalid(v_in1),
    .outread(rd1), .routport(res1), .rvalidport(rv1));

  sa_core #(.ROWS(R2), .KDEPTH(K2)) u_dut2 (
    .clk(clk), .rstn(rstn2), .ainport(a2), .winport(w2), .inpvalid(v_in2),
    .outread(rd2), .routport(res2), .rvalidport(rv2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, act, act, exp, exp);
  endtask

  // Monitors: every column read is compared against the scoreboard head
  always @(negedge clk) begin
    if (rd1 && rv1 != '0) begin
      chk("mon1_valid_all", 32'(rv1), 32'hFF);
      for (int r = 0; r < R1; r++) begin
        if (q1.size() == 0) begin
          n_checks++;
          $display("FAIL mon1_unexpected_pop: row %0d got %0d expected no data", r, res1[r]);
        end else begin
          chk($sformatf("mon1_row%0d", r), res1[r], q1.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rd2 && rv2 != '0) begin
      chk("mon2_valid_all", 32'(rv2), 32'h3);
      for (int r = 0; r < R2; r++) begin
        if (q2.size() == 0) begin
          n_checks++;
          $display("FAIL mon2_unexpected_pop: row %0d got %0d expected no data", r, res2[r]);
        end else begin
          chk($sformatf("mon2_row%0d", r), res2[r], q2.pop_front());
        end
      end
    end
  end

  task automatic step1(input logic v);
    v_in1 = v;
    @(posedge clk); #1;
    v_in1 = 1'b0;
  endtask

  task automatic set_all1(input data_t av, input data_t wv);
    for (int i = 0; i < R1; i++) begin a1[i] = av; w1[i] = wv; end
  endtask

  task automatic set_ramp1(input int k);
    for (int i = 0; i < R1; i++) begin
      a1[i] = (i < 7) ? data_t'(k) : 8'd0;
      w1[i] = 8'd1;
    end
  endtask

  task automatic push_ramp1();
    for (int c = 0; c < R1; c++)
      for (int r = 0; r < R1; r++)
        q1.push_back((r < 7) ? 32'd28 : 32'd0);
  endtask

  // Called right after the last beat's sampling edge: ready exactly 2*ROWS edges later
  task automatic tend_check1(input string name);
    repeat (2 * R1 - 1) @(posedge clk);
    #1 chk({name, "_not_yet"}, 32'(rv1), 32'h0);
    @(posedge clk); #1;
    chk({name, "_ready"}, 32'(rv1), 32'hFF);
  endtask

  task automatic drain1(input int gap);
    for (int i = 0; i < R1; i++) begin
      rd1 = 1'b1;
      @(posedge clk); #1;
      rd1 = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic empty_check1(input string name);
    chk({name, "_rvalid0"}, 32'(rv1), 32'h0);
    chk({name, "_rout0"}, res1[0], 32'h0);
  endtask

  task automatic run_dut1();
    // 1: reset, then a mid-stream reset with a full buffer and a partial tile
    @(posedge clk); #1;
    chk("reset_rvalid", 32'(rv1), 32'h0);
    chk("reset_rout0", res1[0], 32'h0);
    chk("reset_rout7", res1[7], 32'h0);
    rstn1 = 1'b1;
    set_all1(8'd5, 8'd5);
    for (int k = 0; k < 11; k++) step1(1'b1);
    repeat (20) @(posedge clk);
    #1 chk("prereset_full", 32'(rv1), 32'hFF);
    rstn1 = 1'b0;
    #2;
    empty_check1("midreset");
    @(posedge clk); #1;
    rstn1 = 1'b1;
    @(posedge clk); #1;

    // 2: ramp, contiguous beats
    for (int k = 0; k < 8; k++) begin set_ramp1(k); step1(1'b1); end
    tend_check1("ramp");
    push_ramp1();
    drain1(0);
    empty_check1("ramp_drained");

    // 3: same beats with bubbles carrying junk data
    for (int k = 0; k < 8; k++) begin
      set_ramp1(k);
      step1(1'b1);
      if (k < 7) begin set_all1(8'd99, 8'd99); step1(1'b0); end
    end
    tend_check1("bubble");
    push_ramp1();
    // 4: drain with gaps between pops
    drain1(2);
    empty_check1("bubble_drained");

    // 5: two back-to-back tiles, the second held until the first drains
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < R1; i++) begin a1[i] = data_t'(i + 1); w1[i] = data_t'(i + 1); end
      step1(1'b1);
    end
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < R1; i++) begin a1[i] = data_t'(i); w1[i] = data_t'(7 - i); end
      step1(1'b1);
    end
    repeat (7) @(posedge clk);
    #1 chk("b2b_a_not_yet", 32'(rv1), 32'h0);
    @(posedge clk); #1;
    chk("b2b_a_ready", 32'(rv1), 32'hFF);
    repeat (12) @(posedge clk);
    #1;
    set_all1(8'd200, 8'd200);
    for (int k = 0; k < 4; k++) step1(1'b1);     // arrive during HOLD
    for (int c = 0; c < R1; c++)
      for (int r = 0; r < R1; r++)
        q1.push_back(32'(8 * (r + 1) * (c + 1)));
    for (int c = 0; c < R1; c++)
      for (int r = 0; r < R1; r++)
        q1.push_back(32'(8 * r * (7 - c)));
    drain1(0);
    chk("copy_wins_rvalid", 32'(rv1), 32'hFF);
    drain1(1);
    empty_check1("b2b_drained");
    // A clean tile afterwards shows the HOLD beats were not counted
    for (int k = 0; k < 8; k++) begin set_ramp1(k); step1(1'b1); end
    tend_check1("post_hold");
    push_ramp1();
    drain1(0);

    // 6: maximum operands, no overflow at KDEPTH=8
    set_all1(8'd255, 8'd255);
    for (int k = 0; k < 8; k++) step1(1'b1);
    tend_check1("max");
    for (int i = 0; i < R1 * R1; i++) q1.push_back(32'd520200);
    drain1(0);
    empty_check1("max_drained");
  endtask

  task automatic run_dut2();
    repeat (3) @(posedge clk);
    #1 rstn2 = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < K2; k++) begin
      v_in2 = 1'b1;
      @(posedge clk); #1;
    end
    v_in2 = 1'b0;
    repeat (2 * R2 - 1) @(posedge clk);
    #1 chk("wrap_not_yet", 32'(rv2), 32'h0);
    @(posedge clk); #1;
    chk("wrap_ready", 32'(rv2), 32'h3);
    for (int i = 0; i < R2 * R2; i++) q2.push_back(32'd64004);
    for (int i = 0; i < R2; i++) begin
      rd2 = 1'b1;
      @(posedge clk); #1;
      rd2 = 1'b0;
    end
    chk("wrap_drained_rvalid0", 32'(rv2), 32'h0);
  endtask

  initial begin
    rstn1 = 1'b0; rstn2 = 1'b0;
    v_in1 = 1'b0; v_in2 = 1'b0;
    rd1   = 1'b0; rd2   = 1'b0;
    for (int i = 0; i < R1; i++) begin a1[i] = '0; w1[i] = '0; end
    for (int i = 0; i < R2; i++) begin a2[i] = 8'd255; w2[i] = 8'd255; end
    fork
      run_dut1();
      run_dut2();
    join
    repeat (2) @(posedge clk);
    #1;
    chk("q1_drained", q1.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
